// File: rtl/uart_rx_framer_if.sv
// Byte-stream handshake and frame status signals between the UART receiver,
// the framer and the downstream command logic.
interface uart_rx_framer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  frame_ok;
  logic                  frame_err;
  logic [1:0]            err_code;

  // Environment side: drives the byte source and the downstream ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );

  // Framer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_rx_framer.sv
// Store-and-forward packet framer: SOF, LEN, payload, XOR checksum. Good
// frames are drained downstream; bad or stalled frames are dropped with a status pulse.
module uart_rx_framer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input logic              clk,
  input logic              rstn,
  uart_rx_framer_if.slave  bus
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PTR_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       mem_q [MAX_LEN];
  logic                mem_we;
  logic [PTR_W-1:0]    len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]       chk_q, chk_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic          accept, out_xfer, in_frame, timeout_hit, len_bad, last_pay, chk_good;
  logic [DW-1:0] in_byte;
  logic [PTR_W-1:0] rd_next;

  assign in_byte     = bus.in_data;
  assign accept      = bus.in_valid && in_ready_q;
  assign out_xfer    = out_valid_q && bus.out_ready;
  assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_frame && !accept && (tcnt_q == TCNT_LAST);
  assign len_bad     = (in_byte == '0) || (in_byte > DW'(MAX_LEN));
  assign last_pay    = (wr_ptr_q == len_q - PTR_W'(1));
  assign chk_good    = (in_byte == chk_q);
  assign rd_next     = rd_ptr_q + PTR_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_HUNT;
    else       state_q <= state_d;
  end

  // Next-state logic; a timeout overrides everything inside a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HUNT:    if (accept && (in_byte == SOF_BYTE)) state_d = S_LEN;
      S_LEN:     if (accept) state_d = len_bad ? S_HUNT : S_PAYLOAD;
      S_PAYLOAD: if (accept && last_pay) state_d = S_CHK;
      S_CHK:     if (accept) state_d = chk_good ? S_DRAIN : S_HUNT;
      S_DRAIN:   if (out_xfer && out_last_q) state_d = S_HUNT;
      default:   state_d = S_HUNT;
    endcase
    if (timeout_hit) state_d = S_HUNT;
  end

  // Output and datapath next values.
  always_comb begin
    in_ready_d  = (state_d != S_DRAIN);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we      = 1'b0;
    tcnt_d      = '0;
    if ((TIMEOUT_CYCLES != 0) && in_frame && !accept && !timeout_hit) tcnt_d = tcnt_q + TCNT_W'(1);

    unique case (state_q)
      S_LEN: if (accept) begin
        if (len_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end else begin
          len_d    = PTR_W'(in_byte);
          chk_d    = in_byte;
          wr_ptr_d = '0;
        end
      end
      S_PAYLOAD: if (accept) begin
        mem_we   = 1'b1;
        chk_d    = chk_q ^ in_byte;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      S_CHK: if (accept) begin
        if (chk_good) begin
          frame_ok_d  = 1'b1;
          err_code_d  = 2'd0;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
          out_data_d  = mem_q[0];
          out_last_d  = (len_q == PTR_W'(1));
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end
      end
      // Present the next buffered byte as soon as the current one is taken.
      S_DRAIN: if (out_xfer) begin
        if (out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          rd_ptr_d   = rd_next;
          out_data_d = mem_q[IDX_W'(rd_next)];
          out_last_d = (rd_next == len_q - PTR_W'(1));
        end
      end
      default: ;
    endcase

    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q       <= '0;
      chk_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tcnt_q      <= tcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload buffer; contents are meaningless until a frame has been written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[IDX_W'(wr_ptr_q)] <= in_byte;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
Consumes the byte stream from the UART receiver (valid/ready byte handshake) and extracts framed packets. Frame format: SOF, LEN, LEN payload bytes, CHK. Payload is buffered, checked, and released downstream only if the frame is good (store-and-forward). Bad frames are dropped and reported through a status pulse and an error code. Sits between the UART receiver and the command/register logic.

Parameters:
DATA_WIDTH, 8, byte width; fixed at 8, LEN and CHK are one byte each.
MAX_LEN, 16, maximum payload length in bytes (1..255); sets buffer depth.
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYCLES, 100_000, inter-byte timeout in clk cycles while inside a frame; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on posedge.
rstn  in  1  synchronous active-low reset.
in_data  in  8  byte from the UART receiver.
in_valid  in  1  in_data valid.
in_ready  out  1  framer accepts a byte; transfer = in_valid && in_ready.
out_data  out  8  payload byte.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts; transfer = out_valid && out_ready.
out_last  out  1  marks the final payload byte of a frame.
frame_ok  out  1  one-cycle pulse: good frame accepted.
frame_err  out  1  one-cycle pulse: frame dropped.
err_code  out  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.

Behaviour:
- Reset values:
  - state = HUNT; in_ready = 1; out_valid = 0; out_last = 0; out_data = 0.
  - frame_ok = 0; frame_err = 0; err_code = 0.
  - All pointers, counters and the running checksum are 0.
  - Buffer contents are don't-care.
- Reset mid-frame or mid-drain aborts immediately. No pulse is generated. The partial frame is lost.
- in_ready = 1 in HUNT, LEN, PAYLOAD and CHK. in_ready = 0 in DRAIN. Input is not accepted during drain.
- State transitions (each taken on an accepted byte, unless noted):
  - HUNT: byte == SOF_BYTE → LEN. Any other byte is discarded silently, with no pulse.
  - LEN, byte L:
    - L == 0 or L > MAX_LEN → frame_err pulse, err_code = 1, go to HUNT. The byte is consumed.
    - Otherwise: store len = L, running chk = L, wr_ptr = 0, go to PAYLOAD.
  - PAYLOAD: buf[wr_ptr] = byte; chk ^= byte; wr_ptr++. After the L-th byte → CHK.
  - CHK:
    - byte == chk → frame_ok pulse, err_code = 0, rd_ptr = 0, go to DRAIN.
    - Otherwise → frame_err pulse, err_code = 2, go to HUNT.
  - DRAIN:
    - out_valid = 1; out_data = buf[rd_ptr]; out_last = (rd_ptr == len-1).
    - Each output transfer increments rd_ptr.
    - The transfer with out_last → out_valid = 0, go to HUNT.
- Checksum: XOR of the LEN byte and all payload bytes, 8-bit.
- A SOF value appearing inside LEN, PAYLOAD or CHK is ordinary data. There is no resynchronisation mid-frame.
- Latency:
  - CHK accepted in cycle N → frame_ok high in N+1 and out_valid high in N+1 (both registered).
  - Each further byte takes one cycle per transfer when out_ready = 1.
- Output hold: while out_valid = 1 and out_ready = 0, out_data and out_last are held stable.
- frame_ok and frame_err are mutually exclusive and last exactly one cycle. err_code holds until the next frame_ok or frame_err.
- Timeout:
  - tcnt clears on every accepted byte and on entry to LEN.
  - In LEN, PAYLOAD and CHK, tcnt increments each cycle with no accepted byte.
  - tcnt == TIMEOUT_CYCLES-1 with no byte accepted → frame_err pulse, err_code = 3, go to HUNT next cycle.
  - No timeout in HUNT or DRAIN. TIMEOUT_CYCLES = 0 disables the counter.
- Widths: wr_ptr, rd_ptr and len are $clog2(MAX_LEN+1) bits. tcnt is $clog2(TIMEOUT_CYCLES+1) bits. No wrap-around is possible because LEN ≤ MAX_LEN is enforced.
- After a frame_err, the next frame is accepted starting with the very next byte (HUNT is entered the following cycle).

Test Plan:
- Good frame: A5 03 11 22 33 03 with out_ready = 1 → frame_ok one cycle after CHK. Out bytes are 11, 22, 33, with out_last only on 33. err_code = 0. in_ready = 0 until after 33 is transferred.
- Bad checksum: A5 03 11 22 33 04 → frame_err with err_code = 2. out_valid never asserts. A following good frame A5 01 5A 5B → output 5A with out_last.
- Length errors: A5 00 → err_code = 1. A5 11 (17 > MAX_LEN = 16) → err_code = 1. The next byte is treated in HUNT.
- Garbage and in-frame SOF: 00 FF A5 02 A5 A5 02 → garbage dropped. Payload A5 A5 accepted (chk = 02^A5^A5 = 02), frame_ok, output A5, A5.
- Backpressure: good 3-byte frame with out_ready toggled 0/1 every cycle and held low for 10 cycles mid-drain → data stable while stalled, no bytes lost or duplicated, in_ready = 0 throughout DRAIN.
- Timeout and reset (TIMEOUT_CYCLES = 50):
  - A5 02 11 followed by a 50-cycle gap → frame_err with err_code = 3, exactly 50 cycles after 11 is accepted.
  - rstn asserted mid-PAYLOAD of another frame → all outputs return to reset values, no pulse.
